// File: rtl/wbuart_tx_sequencer.sv
// wbuart_tx_sequencer: Wishbone master that programs the wbuart setup
// register once after reset, then for each streamed byte polls the UART FIFO
// status until the TX FIFO has room and writes the byte to the TX data
// register. A bus cycle that goes unanswered for TIMEOUT cycles latches a
// terminal error that only i_reset clears.
//
// Stream handshake: a byte moves when s_valid and s_ready are both high at a
// rising edge. s_ready is registered and high only in READY, and
// s_valid/s_data are ignored while s_ready is low.
module wbuart_tx_sequencer #(
  parameter logic [31:0] SETUP_VAL   = 32'h0000_0364,
  parameter logic [1:0]  ADDR_SETUP  = 2'b00,
  parameter logic [1:0]  ADDR_FIFO   = 2'b01,
  parameter logic [1:0]  ADDR_TXDATA = 2'b11,
  parameter int          TXFULL_BIT  = 16,
  parameter int          TIMEOUT     = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [1:0]  o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_stall,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_data,
  output logic        o_busy,
  output logic        o_err,
  output logic [15:0] o_sent_cnt
);

  typedef enum logic [2:0] {
    ST_CFG, ST_GAP, ST_READY, ST_POLL, ST_WRITE, ST_ERR
  } state_t;

  // Last value the cycle counter may hold before an unanswered cycle is abandoned.
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  state_t      state_q;
  state_t      after_gap_q;   // where GAP leads once its idle cycle is over
  logic [7:0]  byte_q;
  logic [9:0]  tmo_q;
  logic        cyc_q;
  logic        stb_q;
  logic        we_q;
  logic [1:0]  addr_q;
  logic [31:0] data_q;
  logic        s_ready_q;
  logic        busy_q;
  logic        err_q;
  logic [15:0] sent_q;

  // Only the TX-full bit of the status word matters here.
  logic unused_rdata;
  assign unused_rdata = ^i_wb_data;

  // Sequencer FSM: bus transaction tracking, timeout and state walk in one register block.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_CFG;
      after_gap_q <= ST_READY;
      byte_q      <= '0;
      tmo_q       <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b1;
      err_q       <= 1'b0;
      sent_q      <= '0;
    end else if (cyc_q) begin
      // A transaction is in flight: retire stb once accepted, cyc once acked.
      tmo_q <= tmo_q + 10'd1;
      if (!i_wb_stall) begin
        stb_q <= 1'b0;
      end
      if (i_wb_ack) begin
        cyc_q   <= 1'b0;
        stb_q   <= 1'b0;
        state_q <= ST_GAP;
        case (state_q)
          ST_POLL:  after_gap_q <= i_wb_data[TXFULL_BIT] ? ST_POLL : ST_WRITE;
          ST_WRITE: begin
            after_gap_q <= ST_READY;
            sent_q      <= sent_q + 16'd1;
          end
          default:  after_gap_q <= ST_READY;
        endcase
      end else if (tmo_q == TMO_LAST) begin
        cyc_q   <= 1'b0;
        stb_q   <= 1'b0;
        err_q   <= 1'b1;
        state_q <= ST_ERR;
      end
    end else begin
      case (state_q)
        ST_CFG: begin
          cyc_q  <= 1'b1;
          stb_q  <= 1'b1;
          we_q   <= 1'b1;
          addr_q <= ADDR_SETUP;
          data_q <= SETUP_VAL;
          tmo_q  <= '0;
        end
        ST_GAP: begin
          state_q <= after_gap_q;
          case (after_gap_q)
            ST_POLL: begin
              cyc_q  <= 1'b1;
              stb_q  <= 1'b1;
              we_q   <= 1'b0;
              addr_q <= ADDR_FIFO;
              data_q <= '0;
              tmo_q  <= '0;
            end
            ST_WRITE: begin
              cyc_q  <= 1'b1;
              stb_q  <= 1'b1;
              we_q   <= 1'b1;
              addr_q <= ADDR_TXDATA;
              data_q <= {24'h0, byte_q};
              tmo_q  <= '0;
            end
            default: begin
              s_ready_q <= 1'b1;
              busy_q    <= 1'b0;
            end
          endcase
        end
        ST_READY: begin
          if (s_valid && s_ready_q) begin
            byte_q    <= s_data;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= ST_POLL;
            cyc_q     <= 1'b1;
            stb_q     <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= ADDR_FIFO;
            data_q    <= '0;
            tmo_q     <= '0;
          end
        end
        // ERR holds until reset; POLL and WRITE always have cyc high here.
        default: ;
      endcase
    end
  end

  assign s_ready    = s_ready_q;
  assign o_wb_cyc   = cyc_q;
  assign o_wb_stb   = stb_q;
  assign o_wb_we    = we_q;
  assign o_wb_addr  = addr_q;
  assign o_wb_data  = data_q;
  assign o_wb_sel   = 4'b1111;
  assign o_busy     = busy_q;
  assign o_err      = err_q;
  assign o_sent_cnt = sent_q;

endmodule

// File: tb/tb_wbuart_tx_sequencer.sv
// Bench for wbuart_tx_sequencer: a responsive Wishbone slave with
// configurable stall/ack latency, an expected-transaction queue, table
// vectors, randomized bytes, and hand-written timeout/wrap/reset sequences.
module tb_wbuart_tx_sequencer;

  localparam int          TMO   = 8;
  localparam logic [31:0] SETUP = 32'h0000_0364;

  // Clock and reset
  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  always #5 i_clk = ~i_clk;

  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [1:0]  o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_stall = 1'b0;
  logic        i_wb_ack = 1'b0;
  logic [31:0] i_wb_data = 32'h0;
  logic        o_busy, o_err;
  logic [15:0] o_sent_cnt;

  wbuart_tx_sequencer #(.TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data),
    .o_busy(o_busy), .o_err(o_err), .o_sent_cnt(o_sent_cnt)
  );

  // Scoreboard state
  int n_vec = 0;
  int n_miss = 0;
  logic [34:0] exp_q[$];   // {we, addr, data}; data ignored for reads
  logic [31:0] st_q[$];    // status words returned to successive polls

  // Slave configuration
  bit cfg_rand = 1'b0;
  int cfg_stall = 0;
  int cfg_dly = 1;
  bit cfg_ack_en = 1'b1;
  int exp_cyc_acc = 0;     // expected handshake-to-ready cycles, built per transaction
  int poll_cnt = 0;

  typedef struct {
    logic [7:0] data;
    int n_full;
    int stall;
    int dly;
    int exp_cyc;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_byte_txns(input logic [7:0] d, input int n_full);
    logic [31:0] st;
    for (int i = 0; i <= n_full; i++) begin
      exp_q.push_back({1'b0, 2'b01, 32'h0});
      st = $urandom;
      if (i < n_full) st = st | 32'h0001_0000;
      else            st = st & 32'hFFFE_FFFF;
      st_q.push_back(st);
    end
    exp_q.push_back({1'b1, 2'b11, {24'h0, d}});
  endtask

  // Offer a byte, wait for the handshake, then count cycles until s_ready returns.
  task automatic send_byte(input logic [7:0] d, output int cycles);
    int k;
    k = 0;
    s_data = d;
    s_valid = 1'b1;
    while (!s_ready && k < 200) begin
      tick();
      k++;
    end
    if (!s_ready) begin
      check("handshake_wait", {31'h0, s_ready}, 32'h1);
      s_valid = 1'b0;
      cycles = -1;
      return;
    end
    exp_cyc_acc = 1;
    tick();
    s_valid = 1'b0;
    s_data = 8'($urandom);
    cycles = 1;
    while (!s_ready && cycles < 300) begin
      tick();
      cycles++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cyc"},   {31'h0, o_wb_cyc}, 32'h0);
    check({tag, "_stb"},   {31'h0, o_wb_stb}, 32'h0);
    check({tag, "_we"},    {31'h0, o_wb_we}, 32'h0);
    check({tag, "_addr"},  {30'h0, o_wb_addr}, 32'h0);
    check({tag, "_data"},  o_wb_data, 32'h0);
    check({tag, "_sel"},   {28'h0, o_wb_sel}, 32'hF);
    check({tag, "_ready"}, {31'h0, s_ready}, 32'h0);
    check({tag, "_busy"},  {31'h0, o_busy}, 32'h1);
    check({tag, "_err"},   {31'h0, o_err}, 32'h0);
    check({tag, "_sent"},  {16'h0, o_sent_cnt}, 32'h0);
  endtask

  // Release reset and expect the setup write to start at once and finish into READY.
  task automatic release_and_config(input string tag);
    int k;
    i_reset = 1'b0;
    tick();
    check({tag, "_cfg_cyc"},  {31'h0, o_wb_cyc}, 32'h1);
    check({tag, "_cfg_stb"},  {31'h0, o_wb_stb}, 32'h1);
    check({tag, "_cfg_we"},   {31'h0, o_wb_we}, 32'h1);
    check({tag, "_cfg_addr"}, {30'h0, o_wb_addr}, 32'h0);
    k = 0;
    while (!s_ready && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_cfg_to_ready"}, k, 32'd3);
  endtask

  // Slave model: stalls, acks, returns status words and checks each transaction.
  initial begin : slave
    bit in_txn, prev_ack, do_ack;
    logic t_we;
    logic [1:0] t_addr;
    logic [31:0] t_data;
    logic [34:0] e;
    int t_stall, t_dly, stall_left, ack_left, stb_cnt, cyc_cnt;
    in_txn = 0; prev_ack = 0;
    t_we = 0; t_addr = 0; t_data = 0;
    t_stall = 0; t_dly = 0; stall_left = 0; ack_left = 0; stb_cnt = 0; cyc_cnt = 0;
    forever begin
      tick();
      i_wb_ack = 1'b0;
      i_wb_stall = 1'b0;
      i_wb_data = $urandom;
      do_ack = 1'b0;
      check("busy_vs_ready", {31'h0, o_busy}, {31'h0, ~s_ready});
      if (prev_ack) begin
        check("cyc_drop_after_ack", {31'h0, o_wb_cyc}, 32'h0);
        prev_ack = 1'b0;
      end
      if (!o_wb_cyc) begin
        in_txn = 1'b0;
      end else begin
        if (!in_txn) begin
          in_txn = 1'b1;
          t_we = o_wb_we; t_addr = o_wb_addr; t_data = o_wb_data;
          check("cyc_stb_rise", {31'h0, o_wb_stb}, 32'h1);
          if (cfg_rand) begin
            t_stall = $urandom_range(0, 2);
            t_dly = $urandom_range(0, 2);
          end else begin
            t_stall = cfg_stall;
            t_dly = cfg_dly;
          end
          exp_cyc_acc += t_stall + t_dly + 2;
          stall_left = t_stall; ack_left = 0; stb_cnt = 0; cyc_cnt = 0;
          if (!t_we && t_addr == 2'b01) poll_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_txn_addr", {30'h0, t_addr}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("txn_we", {31'h0, t_we}, {31'h0, e[34]});
            check("txn_addr", {30'h0, t_addr}, {30'h0, e[33:32]});
            if (e[34]) check("txn_wdata", t_data, e[31:0]);
          end
        end else begin
          check("bus_stable", {o_wb_addr, o_wb_data[29:0]}, {t_addr, t_data[29:0]});
          check("bus_stable_hi", {29'h0, o_wb_we, o_wb_data[31:30]}, {29'h0, t_we, t_data[31:30]});
        end
        cyc_cnt++;
        if (o_wb_stb) begin
          stb_cnt++;
          if (stall_left > 0) begin
            i_wb_stall = 1'b1;
            stall_left--;
          end else if (t_dly == 0) begin
            do_ack = 1'b1;
          end else begin
            ack_left = t_dly;
          end
        end else if (ack_left > 0) begin
          ack_left--;
          if (ack_left == 0) do_ack = 1'b1;
        end
        if (do_ack && cfg_ack_en) begin
          i_wb_ack = 1'b1;
          if (!t_we) i_wb_data = (st_q.size() > 0) ? st_q.pop_front() : 32'h0;
          check("stb_cycles", stb_cnt, t_stall + 1);
          check("cyc_cycles", cyc_cnt, t_stall + 1 + t_dly);
          prev_ack = 1'b1;
        end
      end
    end
  end

  // Stimulus and checks
  initial begin : main
    int cycles, k, bad, n_full;
    logic [7:0] d;
    logic [15:0] sent_exp;

    // data, polls reporting full, stall, ack delay, handshake-to-ready cycles
    vecs[0] = '{8'h41, 0, 0, 1, 7};
    vecs[1] = '{8'h5A, 0, 0, 1, 7};
    vecs[2] = '{8'hC3, 3, 0, 1, 16};
    vecs[3] = '{8'h00, 0, 1, 0, 7};
    vecs[4] = '{8'hFF, 1, 2, 2, 19};
    vecs[5] = '{8'h7E, 0, 0, 0, 5};
    vecs[6] = '{8'h33, 0, 3, 1, 13};

    exp_q.push_back({1'b1, 2'b00, SETUP});
    i_reset = 1'b1;
    repeat (3) tick();
    check_reset_values("por");
    release_and_config("por");

    // Table vectors
    sent_exp = 16'h0;
    for (int i = 0; i < 7; i++) begin
      cfg_stall = vecs[i].stall;
      cfg_dly = vecs[i].dly;
      poll_cnt = 0;
      push_byte_txns(vecs[i].data, vecs[i].n_full);
      send_byte(vecs[i].data, cycles);
      check($sformatf("vec%0d_cycles", i), cycles, vecs[i].exp_cyc);
      check($sformatf("vec%0d_polls", i), poll_cnt, vecs[i].n_full + 1);
      sent_exp++;
      check($sformatf("vec%0d_sent", i), {16'h0, o_sent_cnt}, {16'h0, sent_exp});
      check($sformatf("vec%0d_err", i), {31'h0, o_err}, 32'h0);
    end

    // Randomized bytes, polls and slave latencies
    cfg_rand = 1'b1;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      d = 8'($urandom);
      n_full = $urandom_range(0, 3);
      poll_cnt = 0;
      push_byte_txns(d, n_full);
      send_byte(d, cycles);
      check($sformatf("rnd%0d_cycles", i), cycles, exp_cyc_acc);
      check($sformatf("rnd%0d_polls", i), poll_cnt, n_full + 1);
      sent_exp++;
      check($sformatf("rnd%0d_sent", i), {16'h0, o_sent_cnt}, {16'h0, sent_exp});
    end
    cfg_rand = 1'b0;
    cfg_stall = 0;
    cfg_dly = 1;

    // Sent counter wrap
    force dut.sent_q = 16'hFFFF;
    tick();
    release dut.sent_q;
    tick();
    check("wrap_preload", {16'h0, o_sent_cnt}, 32'hFFFF);
    push_byte_txns(8'h99, 0);
    send_byte(8'h99, cycles);
    check("wrap_cycles", cycles, 32'd7);
    check("wrap_sent", {16'h0, o_sent_cnt}, 32'h0);

    // Timeout during POLL
    cfg_ack_en = 1'b0;
    exp_q.push_back({1'b0, 2'b01, 32'h0});
    s_data = 8'hA5;
    s_valid = 1'b1;
    k = 0;
    while (!s_ready && k < 50) begin
      tick();
      k++;
    end
    check("tmo_ready", {31'h0, s_ready}, 32'h1);
    tick();
    check("tmo_cyc_rise", {31'h0, o_wb_cyc}, 32'h1);
    k = 0;
    while (o_wb_cyc && k < 50) begin
      k++;
      tick();
    end
    check("tmo_cyc_len", k, TMO);
    check("tmo_err", {31'h0, o_err}, 32'h1);
    check("tmo_busy", {31'h0, o_busy}, 32'h1);
    check("tmo_sready", {31'h0, s_ready}, 32'h0);
    bad = 0;
    repeat (12) begin
      tick();
      if (s_ready || o_wb_cyc || !o_err || !o_busy) bad++;
    end
    check("err_terminal_bad_cycles", bad, 32'd0);
    s_valid = 1'b0;
    cfg_ack_en = 1'b1;
    exp_q.delete();
    st_q.delete();
    exp_q.push_back({1'b1, 2'b00, SETUP});
    i_reset = 1'b1;
    tick();
    check_reset_values("tmo_rst");
    release_and_config("tmo_rst");

    // Reset while a stalled cycle is open
    cfg_stall = 5;
    push_byte_txns(8'h3C, 0);
    s_data = 8'h3C;
    s_valid = 1'b1;
    k = 0;
    while (!s_ready && k < 50) begin
      tick();
      k++;
    end
    tick();
    s_valid = 1'b0;
    tick();
    check("mid_cyc_open", {31'h0, o_wb_cyc}, 32'h1);
    i_reset = 1'b1;
    exp_q.delete();
    st_q.delete();
    tick();
    check_reset_values("mid_rst");
    exp_q.push_back({1'b1, 2'b00, SETUP});
    cfg_stall = 0;
    release_and_config("mid_rst");
    check("mid_rst_sent", {16'h0, o_sent_cnt}, 32'h0);

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global time limit
  initial begin : watchdog
    #500000;
    n_miss++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
